// File: rtl/impl_chk_pkg.sv
// Shared types, encodings and width helpers for the impl_chk property checker.
package impl_chk_pkg;

    // Implication mode as presented on mode_i; encoding 3 is treated as OVL.
    typedef logic [1:0] mode_e;
    localparam mode_e MODE_OVL     = 2'd0;
    localparam mode_e MODE_NOV     = 2'd1;
    localparam mode_e MODE_IMPLIES = 2'd2;

    // Per-lane FSM state encoding.
    typedef logic [2:0] state_e;
    localparam state_e ST_IDLE = 3'd0;
    localparam state_e ST_ANT  = 3'd1;
    localparam state_e ST_GAP  = 3'd2;
    localparam state_e ST_CON  = 3'd3;
    localparam state_e ST_PAR  = 3'd4;

    // Width of a counter that indexes 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to hold a population count of n bits.
    function automatic int unsigned pop_w(input int unsigned n);
        return (n > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/impl_chk_lane.sv
// One checker channel: rose detection, attempt FSM, s1/s2 sample counters and
// registered pass/fail/vacuous/drop pulses.
module impl_chk_lane #(
    parameter int unsigned ANT_LEN = 2,
    parameter int unsigned CON_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [1:0] mode_i,
    input  logic       a_i,
    input  logic       b_i,
    output logic       pass_o,
    output logic       fail_o,
    output logic       vac_o,
    output logic       drop_o,
    output logic       busy_o,
    output logic       err_sticky_o
);
    import impl_chk_pkg::*;

    localparam int unsigned ANT_W = cnt_w(ANT_LEN);
    localparam int unsigned CON_W = cnt_w(CON_LEN);
    localparam logic [ANT_W-1:0] ANT_LAST = ANT_W'(ANT_LEN - 1);
    localparam logic [CON_W-1:0] CON_LAST = CON_W'(CON_LEN - 1);

    logic             a_q;
    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [ANT_W-1:0] ant_cnt_q, ant_cnt_d;
    logic [CON_W-1:0] con_cnt_q, con_cnt_d;
    logic             s1_ok_q, s1_ok_d;
    logic             s2_bad_q, s2_bad_d;
    logic             pass_q, fail_q, vac_q, drop_q, busy_q, err_q;

    logic             rose_c;
    logic             pass_c, fail_c, vac_c, drop_c;
    logic             run_ant_c, run_con_c, run_par_c;
    logic             s1_true_c, s1_false_c, s2_true_c, s2_false_c;

    // Trigger and the parallel-mode sub-results for the current sample.
    assign rose_c     = a_i & ~a_q;
    assign s1_true_c  = s1_ok_q | (a_i & (ant_cnt_q == ANT_LAST));
    assign s1_false_c = ~s1_ok_q & ~a_i;
    assign s2_true_c  = ~s2_bad_q & b_i & (con_cnt_q == CON_LAST);
    assign s2_false_c = s2_bad_q | ~b_i;

    // Next-state and decision logic; counters/flags are kept zero while idle.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        ant_cnt_d = ant_cnt_q;
        con_cnt_d = con_cnt_q;
        s1_ok_d   = s1_ok_q;
        s2_bad_d  = s2_bad_q;
        pass_c    = 1'b0;
        fail_c    = 1'b0;
        vac_c     = 1'b0;
        run_ant_c = 1'b0;
        run_con_c = 1'b0;
        run_par_c = 1'b0;
        drop_c    = en_i & rose_c & (state_q != ST_IDLE);

        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rose_c) begin
                        mode_d = (mode_i == MODE_NOV || mode_i == MODE_IMPLIES) ? mode_i : MODE_OVL;
                        if (mode_d == MODE_IMPLIES) run_par_c = 1'b1;
                        else                        run_ant_c = 1'b1;
                    end
                end
                ST_ANT:         run_ant_c = 1'b1;
                ST_GAP, ST_CON: run_con_c = 1'b1;
                ST_PAR:         run_par_c = 1'b1;
                default:        state_d   = ST_IDLE;
            endcase

            // s1 only: first low a is vacuous; OVL samples b in the match cycle too.
            if (run_ant_c) begin
                if (!a_i) begin
                    vac_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (ant_cnt_q == ANT_LAST) begin
                    if (mode_d == MODE_NOV) state_d   = ST_GAP;
                    else                    run_con_c = 1'b1;
                end else begin
                    state_d   = ST_ANT;
                    ant_cnt_d = ant_cnt_q + ANT_W'(1);
                end
            end

            // s2 only: first low b fails, last high sample passes.
            if (run_con_c) begin
                if (!b_i) begin
                    fail_c  = 1'b1;
                    state_d = ST_IDLE;
                end else if (con_cnt_q == CON_LAST) begin
                    pass_c  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_CON;
                    con_cnt_d = con_cnt_q + CON_W'(1);
                end
            end

            // IMPLIES: vacuity wins, then s2 success, then fail once both are known.
            if (run_par_c) begin
                if (s1_false_c) begin
                    vac_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (s2_true_c) begin
                    pass_c  = 1'b1;
                    state_d = ST_IDLE;
                end else if (s1_true_c && s2_false_c) begin
                    fail_c  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_PAR;
                    s1_ok_d  = s1_true_c;
                    s2_bad_d = s2_false_c;
                    if (!s1_true_c)  ant_cnt_d = ant_cnt_q + ANT_W'(1);
                    if (!s2_false_c) con_cnt_d = con_cnt_q + CON_W'(1);
                end
            end
        end

        if (state_d == ST_IDLE) begin
            ant_cnt_d = '0;
            con_cnt_d = '0;
            s1_ok_d   = 1'b0;
            s2_bad_d  = 1'b0;
        end
    end

    // Lane state and registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= 1'b0;
            state_q   <= ST_IDLE;
            mode_q    <= MODE_OVL;
            ant_cnt_q <= '0;
            con_cnt_q <= '0;
            s1_ok_q   <= 1'b0;
            s2_bad_q  <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            vac_q     <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            a_q       <= a_i;
            state_q   <= state_d;
            mode_q    <= mode_d;
            ant_cnt_q <= ant_cnt_d;
            con_cnt_q <= con_cnt_d;
            s1_ok_q   <= s1_ok_d;
            s2_bad_q  <= s2_bad_d;
            pass_q    <= pass_c;
            fail_q    <= fail_c;
            vac_q     <= vac_c;
            drop_q    <= drop_c;
            busy_q    <= (state_d != ST_IDLE);
            if (clr_i)       err_q <= 1'b0;
            else if (fail_c) err_q <= 1'b1;
        end
    end

    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign vac_o        = vac_q;
    assign drop_o       = drop_q;
    assign busy_o       = busy_q;
    assign err_sticky_o = err_q;

endmodule

// File: rtl/impl_chk.sv
// Multi-channel implication checker: N_CH independent lanes plus saturating
// global pass/fail event counters.
module impl_chk #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned ANT_LEN = 2,
    parameter int unsigned CON_LEN = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [1:0]       mode_i,
    input  logic [N_CH-1:0]  a_i,
    input  logic [N_CH-1:0]  b_i,
    output logic [N_CH-1:0]  pass_o,
    output logic [N_CH-1:0]  fail_o,
    output logic [N_CH-1:0]  vac_o,
    output logic [N_CH-1:0]  drop_o,
    output logic [N_CH-1:0]  busy_o,
    output logic [N_CH-1:0]  err_sticky_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);
    import impl_chk_pkg::*;

    localparam int unsigned PC_W  = pop_w(N_CH);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [N_CH-1:0]  pass_w, fail_w;
    logic [PC_W-1:0]  pass_pc_c, fail_pc_c;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

    // Add a popcount to a counter, clamping at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [PC_W-1:0]  inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        impl_chk_lane #(
            .ANT_LEN (ANT_LEN),
            .CON_LEN (CON_LEN)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .en_i         (en_i),
            .clr_i        (clr_i),
            .mode_i       (mode_i),
            .a_i          (a_i[g]),
            .b_i          (b_i[g]),
            .pass_o       (pass_w[g]),
            .fail_o       (fail_w[g]),
            .vac_o        (vac_o[g]),
            .drop_o       (drop_o[g]),
            .busy_o       (busy_o[g]),
            .err_sticky_o (err_sticky_o[g])
        );
    end

    // Count this cycle's pass/fail pulses and form the next counter values.
    always_comb begin
        pass_pc_c = '0;
        fail_pc_c = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            pass_pc_c = pass_pc_c + PC_W'(pass_w[i]);
            fail_pc_c = fail_pc_c + PC_W'(fail_w[i]);
        end
        pass_cnt_d = clr_i ? '0 : sat_add(pass_cnt_q, pass_pc_c);
        fail_cnt_d = clr_i ? '0 : sat_add(fail_cnt_q, fail_pc_c);
    end

    // Global event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign pass_o     = pass_w;
    assign fail_o     = fail_w;
    assign pass_cnt_o = pass_cnt_q;
    assign fail_cnt_o = fail_cnt_q;

endmodule

// File: tb/tb_impl_chk.sv
// Directed bench for impl_chk (N_CH=4, ANT_LEN=2, CON_LEN=3, CNT_W=4 so that
// saturation is reachable in a short run).
module tb_impl_chk;
    localparam int unsigned N_CH  = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en_i;
    logic             clr_i;
    logic [1:0]       mode_i;
    logic [N_CH-1:0]  a_i, b_i;
    logic [N_CH-1:0]  pass_o, fail_o, vac_o, drop_o, busy_o, err_sticky_o;
    logic [CNT_W-1:0] pass_cnt_o, fail_cnt_o;

    int n_chk = 0;
    int n_err = 0;

    impl_chk #(
        .N_CH    (N_CH),
        .ANT_LEN (2),
        .CON_LEN (3),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .clr_i        (clr_i),
        .mode_i       (mode_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .pass_o       (pass_o),
        .fail_o       (fail_o),
        .vac_o        (vac_o),
        .drop_o       (drop_o),
        .busy_o       (busy_o),
        .err_sticky_o (err_sticky_o),
        .pass_cnt_o   (pass_cnt_o),
        .fail_cnt_o   (fail_cnt_o)
    );

    always #5 clk = ~clk;

    // Apply one sample and observe the registered result just after the edge.
    task automatic drive(input logic [N_CH-1:0] a, input logic [N_CH-1:0] b);
        a_i = a;
        b_i = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if ({pass_o, fail_o, vac_o, drop_o} !== 16'h0) begin n_err++; $display("FAIL reset_pulses: got %h want 0", {pass_o, fail_o, vac_o, drop_o}); end
        n_chk++; if ({busy_o, err_sticky_o} !== 8'h0) begin n_err++; $display("FAIL reset_busy_err: got %h want 0", {busy_o, err_sticky_o}); end
        n_chk++; if ({pass_cnt_o, fail_cnt_o} !== 8'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", {pass_cnt_o, fail_cnt_o}); end
        rst_n = 1'b1;
        drive(4'h0, 4'h0);
        n_chk++; if (busy_o !== 4'h0) begin n_err++; $display("FAIL post_reset_busy: got %b want 0000", busy_o); end
    endtask

    // OVL: s1 matches t1, s2 covers t1..t3, b low at t3.
    task automatic test_ovl_fail;
        mode_i = 2'd0;
        drive(4'h1, 4'h1);
        n_chk++; if (busy_o !== 4'h1) begin n_err++; $display("FAIL ovl_busy_t0: got %b want 0001", busy_o); end
        drive(4'h1, 4'h1);
        drive(4'h1, 4'h1);
        n_chk++; if (fail_o !== 4'h0) begin n_err++; $display("FAIL ovl_fail_t2: got %b want 0000", fail_o); end
        drive(4'h0, 4'h0);
        n_chk++; if (fail_o !== 4'h1) begin n_err++; $display("FAIL ovl_fail_t3: got %b want 0001", fail_o); end
        n_chk++; if (busy_o !== 4'h0) begin n_err++; $display("FAIL ovl_busy_t3: got %b want 0000", busy_o); end
        n_chk++; if (err_sticky_o !== 4'h1) begin n_err++; $display("FAIL ovl_sticky: got %b want 0001", err_sticky_o); end
        drive(4'h0, 4'h0);
        n_chk++; if (fail_cnt_o !== 4'd1) begin n_err++; $display("FAIL ovl_fail_cnt: got %0d want 1", fail_cnt_o); end
    endtask

    // IMPLIES: s1 true at t1, s2 true at t2 -> pass at t2.
    task automatic test_implies_pass;
        mode_i = 2'd2;
        drive(4'h0, 4'h0);
        drive(4'h1, 4'h1);
        drive(4'h1, 4'h1);
        n_chk++; if (pass_o !== 4'h0) begin n_err++; $display("FAIL imp_pass_t1: got %b want 0000", pass_o); end
        drive(4'h1, 4'h1);
        n_chk++; if (pass_o !== 4'h1) begin n_err++; $display("FAIL imp_pass_t2: got %b want 0001", pass_o); end
        n_chk++; if (fail_o !== 4'h0) begin n_err++; $display("FAIL imp_fail_t2: got %b want 0000", fail_o); end
        drive(4'h0, 4'h0);
        n_chk++; if (pass_cnt_o !== 4'd1) begin n_err++; $display("FAIL imp_pass_cnt: got %0d want 1", pass_cnt_o); end
    endtask

    // NOV: s2 window t2..t4.
    task automatic test_nov;
        mode_i = 2'd1;
        drive(4'h0, 4'h0);
        drive(4'h1, 4'h1);
        drive(4'h1, 4'h1);
        drive(4'h1, 4'h1);
        n_chk++; if (fail_o !== 4'h0) begin n_err++; $display("FAIL nov_fail_t2: got %b want 0000", fail_o); end
        drive(4'h0, 4'h0);
        n_chk++; if (fail_o !== 4'h1) begin n_err++; $display("FAIL nov_fail_t3: got %b want 0001", fail_o); end
        drive(4'h0, 4'h0);
        n_chk++; if (fail_cnt_o !== 4'd2) begin n_err++; $display("FAIL nov_fail_cnt: got %0d want 2", fail_cnt_o); end
        for (int t = 0; t < 4; t++) drive(4'h1, 4'h1);
        n_chk++; if (pass_o !== 4'h0 || busy_o !== 4'h1) begin n_err++; $display("FAIL nov_pass_t3: got pass %b busy %b want 0000 0001", pass_o, busy_o); end
        drive(4'h1, 4'h1);
        n_chk++; if (pass_o !== 4'h1) begin n_err++; $display("FAIL nov_pass_t4: got %b want 0001", pass_o); end
        drive(4'h0, 4'h0);
        n_chk++; if (pass_cnt_o !== 4'd2) begin n_err++; $display("FAIL nov_pass_cnt: got %0d want 2", pass_cnt_o); end
    endtask

    task automatic test_vacuous;
        mode_i = 2'd0;
        drive(4'h1, 4'h1);
        drive(4'h0, 4'h1);
        n_chk++; if ({vac_o, pass_o, fail_o} !== 12'h100) begin n_err++; $display("FAIL ovl_vac_t1: got vac/pass/fail %h want 100", {vac_o, pass_o, fail_o}); end
        drive(4'h0, 4'h0);
        mode_i = 2'd2;
        drive(4'h1, 4'h0);
        n_chk++; if ({vac_o, fail_o, busy_o} !== 12'h001) begin n_err++; $display("FAIL imp_vac_t0: got vac/fail/busy %h want 001", {vac_o, fail_o, busy_o}); end
        drive(4'h0, 4'h0);
        n_chk++; if ({vac_o, fail_o} !== 8'h10) begin n_err++; $display("FAIL imp_vac_t1: got vac/fail %h want 10", {vac_o, fail_o}); end
        drive(4'h0, 4'h0);
        n_chk++; if ({pass_cnt_o, fail_cnt_o} !== 8'h22) begin n_err++; $display("FAIL vac_counts: got %h want 22", {pass_cnt_o, fail_cnt_o}); end
    endtask

    // Second rose lands on the deciding sample of an OVL attempt.
    task automatic test_drop;
        mode_i = 2'd0;
        drive(4'h1, 4'h1);
        drive(4'h1, 4'h1);
        drive(4'h0, 4'h1);
        drive(4'h1, 4'h1);
        n_chk++; if (pass_o !== 4'h1 || drop_o !== 4'h1) begin n_err++; $display("FAIL drop_t3: got pass %b drop %b want 0001 0001", pass_o, drop_o); end
        drive(4'h1, 4'h0);
        n_chk++; if ({pass_o, fail_o, vac_o, drop_o, busy_o} !== 20'h0) begin n_err++; $display("FAIL drop_single: got %h want 0", {pass_o, fail_o, vac_o, drop_o, busy_o}); end
        n_chk++; if (pass_cnt_o !== 4'd3) begin n_err++; $display("FAIL drop_pass_cnt: got %0d want 3", pass_cnt_o); end
        drive(4'h0, 4'h0);
    endtask

    task automatic test_enable;
        mode_i = 2'd0;
        drive(4'h1, 4'h1);
        en_i = 1'b0;
        drive(4'h1, 4'h1);
        n_chk++; if ({busy_o, pass_o, fail_o, vac_o} !== 16'h0) begin n_err++; $display("FAIL en_abort: got %h want 0", {busy_o, pass_o, fail_o, vac_o}); end
        en_i = 1'b1;
        drive(4'h1, 4'h1);
        drive(4'h1, 4'h1);
        n_chk++; if ({busy_o, pass_o, fail_o, vac_o, drop_o} !== 20'h0) begin n_err++; $display("FAIL en_no_rose: got %h want 0", {busy_o, pass_o, fail_o, vac_o, drop_o}); end
        drive(4'h0, 4'h0);
    endtask

    task automatic test_reset_mid;
        mode_i = 2'd0;
        drive(4'h1, 4'h1);
        rst_n = 1'b0;
        a_i   = 4'h0;
        b_i   = 4'h0;
        #1;
        n_chk++; if ({busy_o, err_sticky_o, pass_cnt_o, fail_cnt_o} !== 16'h0) begin n_err++; $display("FAIL rst_async: got %h want 0", {busy_o, err_sticky_o, pass_cnt_o, fail_cnt_o}); end
        drive(4'h0, 4'h0);
        drive(4'h0, 4'h0);
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            drive(4'h0, 4'h0);
            n_chk++; if ({pass_o, fail_o, vac_o, busy_o} !== 16'h0) begin n_err++; $display("FAIL rst_no_pulse %0d: got %h want 0", t, {pass_o, fail_o, vac_o, busy_o}); end
        end
        n_chk++; if ({pass_cnt_o, fail_cnt_o} !== 8'h0) begin n_err++; $display("FAIL rst_counts: got %h want 0", {pass_cnt_o, fail_cnt_o}); end
    endtask

    // IMPLIES pass on the channels in m, then check the running pass count.
    task automatic sat_attempt(input logic [N_CH-1:0] m, input logic [CNT_W-1:0] exp_cnt);
        drive(m, m);
        drive(m, m);
        drive(m, m);
        n_chk++; if (pass_o !== m) begin n_err++; $display("FAIL sat_pass_o: got %b want %b", pass_o, m); end
        drive(4'h0, 4'h0);
        drive(4'h0, 4'h0);
        n_chk++; if (pass_cnt_o !== exp_cnt) begin n_err++; $display("FAIL sat_cnt: got %0d want %0d", pass_cnt_o, exp_cnt); end
    endtask

    task automatic test_saturation;
        mode_i = 2'd2;
        sat_attempt(4'hF, 4'd4);
        sat_attempt(4'hF, 4'd8);
        sat_attempt(4'hF, 4'd12);
        sat_attempt(4'h1, 4'd13);
        sat_attempt(4'hF, 4'd15);
        sat_attempt(4'h2, 4'd15);
    endtask

    task automatic test_clr_fail;
        mode_i = 2'd0;
        drive(4'h1, 4'h1);
        drive(4'h1, 4'h1);
        drive(4'h1, 4'h1);
        drive(4'h0, 4'h0);
        drive(4'h0, 4'h0);
        n_chk++; if (fail_cnt_o !== 4'd1) begin n_err++; $display("FAIL clr_pre_cnt: got %0d want 1", fail_cnt_o); end
        drive(4'h1, 4'h1);
        drive(4'h1, 4'h1);
        drive(4'h1, 4'h1);
        clr_i = 1'b1;
        drive(4'h0, 4'h0);
        n_chk++; if (fail_o !== 4'h1) begin n_err++; $display("FAIL clr_fail_pulse: got %b want 0001", fail_o); end
        drive(4'h0, 4'h0);
        clr_i = 1'b0;
        n_chk++; if ({pass_cnt_o, fail_cnt_o} !== 8'h0) begin n_err++; $display("FAIL clr_counts: got %h want 0", {pass_cnt_o, fail_cnt_o}); end
        n_chk++; if (err_sticky_o !== 4'h0) begin n_err++; $display("FAIL clr_sticky: got %b want 0000", err_sticky_o); end
        drive(4'h0, 4'h0);
        n_chk++; if (fail_cnt_o !== 4'd0) begin n_err++; $display("FAIL clr_hold: got %0d want 0", fail_cnt_o); end
    endtask

    initial begin
        rst_n  = 1'b0;
        en_i   = 1'b1;
        clr_i  = 1'b0;
        mode_i = 2'd0;
        a_i    = '0;
        b_i    = '0;
        test_reset();
        test_ovl_fail();
        test_implies_pass();
        test_nov();
        test_vacuous();
        test_drop();
        test_enable();
        test_reset_mid();
        test_saturation();
        test_clr_fail();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
